// File: rtl/redirect_ctrl_pkg.sv
// rtl/redirect_ctrl_pkg.sv - shared widths, enable/flush levels, reset data and FSM encodings
package redirect_ctrl_pkg;

    localparam int RV32_ADDR_WIDTH = 32;

    localparam logic JUMP_ENABLE   = 1'b1;
    localparam logic JUMP_DISABLE  = 1'b0;
    localparam logic FLUSH_ENABLE  = 1'b1;
    localparam logic FLUSH_DISABLE = 1'b0;

    localparam logic [RV32_ADDR_WIDTH-1:0] RST_DATA = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/dff_rs.sv
// rtl/dff_rs.sv - resettable D flip-flop with synchronous reset to rst_data
module dff_rs #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_data,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_data;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - pipeline redirect/stall arbitration FSM (trap > mret > jump, divide wait)
module redirect_ctrl
    import redirect_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_jump_en_i,
    input  logic [RV32_ADDR_WIDTH-1:0] ex_jump_addr_i,
    input  logic                       trap_req_i,
    input  logic [RV32_ADDR_WIDTH-1:0] trap_addr_i,
    input  logic                       mret_req_i,
    input  logic [RV32_ADDR_WIDTH-1:0] mret_addr_i,
    input  logic                       div_start_i,
    input  logic                       div_done_i,
    input  logic                       load_use_i,
    output logic                       jump_en_o,
    output logic [RV32_ADDR_WIDTH-1:0] jump_addr_o,
    output logic                       flush_o,
    output logic                       stall_front_o,
    output logic                       stall_ex_o,
    output logic                       bubble_ex_o,
    output logic                       trap_ack_o
);

    state_t                       state, state_next;
    logic                         trap_pend, trap_pend_next;
    logic                         redir, redir_trap;
    logic [RV32_ADDR_WIDTH-1:0]   redir_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            trap_pend <= 1'b0;
        end else begin
            state     <= state_next;
            trap_pend <= trap_pend_next;
        end
    end

    always_comb begin
        state_next     = state;
        trap_pend_next = trap_pend;
        redir          = 1'b0;
        redir_trap     = 1'b0;
        redir_addr     = jump_addr_o;
        stall_front_o  = 1'b0;
        stall_ex_o     = 1'b0;
        bubble_ex_o    = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (trap_req_i) begin
                        redir      = 1'b1;
                        redir_trap = 1'b1;
                        redir_addr = trap_addr_i;
                    end else if (mret_req_i) begin
                        redir      = 1'b1;
                        redir_addr = mret_addr_i;
                    end else if (ex_jump_en_i) begin
                        redir      = 1'b1;
                        redir_addr = ex_jump_addr_i;
                    end
                    if (redir) begin
                        state_next = ST_REDIRECT;
                    end else if (div_start_i) begin
                        state_next = ST_DIV_WAIT;
                    end else if (load_use_i) begin
                        stall_front_o = 1'b1;
                        bubble_ex_o   = 1'b1;
                    end
                end
                // Wrong-path cycle: every request is dropped, a held trap is seen again in IDLE.
                ST_REDIRECT: state_next = ST_IDLE;
                ST_DIV_WAIT: begin
                    if (div_done_i) begin
                        state_next     = ST_IDLE;
                        trap_pend_next = 1'b0;
                        if (trap_pend) begin
                            redir      = 1'b1;
                            redir_trap = 1'b1;
                            redir_addr = trap_addr_i;
                            state_next = ST_REDIRECT;
                        end
                    end else begin
                        stall_front_o = 1'b1;
                        stall_ex_o    = 1'b1;
                        if (trap_req_i) begin
                            trap_pend_next = 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    dff_rs #(.WIDTH(1)) u_jump_en (
        .clk      (clk),
        .rst      (rst),
        .rst_data (JUMP_DISABLE),
        .d        (redir ? JUMP_ENABLE : JUMP_DISABLE),
        .q        (jump_en_o)
    );

    dff_rs #(.WIDTH(1)) u_flush (
        .clk      (clk),
        .rst      (rst),
        .rst_data (FLUSH_DISABLE),
        .d        (redir ? FLUSH_ENABLE : FLUSH_DISABLE),
        .q        (flush_o)
    );

    dff_rs #(.WIDTH(1)) u_trap_ack (
        .clk      (clk),
        .rst      (rst),
        .rst_data (1'b0),
        .d        (redir_trap),
        .q        (trap_ack_o)
    );

    // Without a redirect the target register recirculates, so it holds its last value.
    dff_rs #(.WIDTH(RV32_ADDR_WIDTH)) u_jump_addr (
        .clk      (clk),
        .rst      (rst),
        .rst_data (RST_DATA),
        .d        (redir_addr),
        .q        (jump_addr_o)
    );

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb/tb_redirect_ctrl.sv - directed and randomized self-checking bench for redirect_ctrl
module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_jump_en = 1'b0;
    logic [31:0] ex_jump_addr = '0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_addr = '0;
    logic        mret_req = 1'b0;
    logic [31:0] mret_addr = '0;
    logic        div_start = 1'b0;
    logic        div_done = 1'b0;
    logic        load_use = 1'b0;
    logic        jump_en_o, flush_o, stall_front_o, stall_ex_o, bubble_ex_o, trap_ack_o;
    logic [31:0] jump_addr_o;

    int vectors = 0;
    int miscompares = 0;

    redirect_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ex_jump_en_i   (ex_jump_en),
        .ex_jump_addr_i (ex_jump_addr),
        .trap_req_i     (trap_req),
        .trap_addr_i    (trap_addr),
        .mret_req_i     (mret_req),
        .mret_addr_i    (mret_addr),
        .div_start_i    (div_start),
        .div_done_i     (div_done),
        .load_use_i     (load_use),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .flush_o        (flush_o),
        .stall_front_o  (stall_front_o),
        .stall_ex_o     (stall_ex_o),
        .bubble_ex_o    (bubble_ex_o),
        .trap_ack_o     (trap_ack_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Reference model: what the pipeline "is doing" rather than an FSM encoding.
    bit          m_just_redirected = 1'b0;
    bit          m_dividing = 1'b0;
    bit          m_trap_waiting = 1'b0;
    bit          m_je = 1'b0;
    bit          m_ack = 1'b0;
    logic [31:0] m_addr = '0;

    always @(posedge clk) begin
        bit          take;
        bit          ack;
        logic [31:0] a;
        take = 1'b0;
        ack  = 1'b0;
        a    = m_addr;
        if (rst) begin
            m_just_redirected = 1'b0;
            m_dividing        = 1'b0;
            m_trap_waiting    = 1'b0;
            a                 = '0;
        end else if (m_dividing) begin
            if (div_done) begin
                if (m_trap_waiting) begin
                    take = 1'b1;
                    ack  = 1'b1;
                    a    = trap_addr;
                end
                m_dividing     = 1'b0;
                m_trap_waiting = 1'b0;
            end else if (trap_req) begin
                m_trap_waiting = 1'b1;
            end
        end else if (!m_just_redirected) begin
            if (trap_req) begin
                take = 1'b1; ack = 1'b1; a = trap_addr;
            end else if (mret_req) begin
                take = 1'b1; a = mret_addr;
            end else if (ex_jump_en) begin
                take = 1'b1; a = ex_jump_addr;
            end else if (div_start) begin
                m_dividing = 1'b1;
            end
        end
        m_just_redirected = take;
        m_je   = take;
        m_ack  = ack;
        m_addr = a;
    end

    always @(negedge clk) begin
        bit e_sf, e_se, e_bub;
        e_sf = 1'b0; e_se = 1'b0; e_bub = 1'b0;
        if (!rst) begin
            if (m_dividing) begin
                e_sf = !div_done;
                e_se = !div_done;
            end else if (!m_just_redirected) begin
                e_sf  = load_use && !(trap_req || mret_req || ex_jump_en || div_start);
                e_bub = e_sf;
            end
        end
        chk("cmp_jump_en",     32'(jump_en_o),     32'(m_je));
        chk("cmp_flush",       32'(flush_o),       32'(m_je));
        chk("cmp_trap_ack",    32'(trap_ack_o),    32'(m_ack));
        chk("cmp_jump_addr",   jump_addr_o,        m_addr);
        chk("cmp_stall_front", 32'(stall_front_o), 32'(e_sf));
        chk("cmp_stall_ex",    32'(stall_ex_o),    32'(e_se));
        chk("cmp_bubble_ex",   32'(bubble_ex_o),   32'(e_bub));
    end

    initial begin
        rst = 1'b1;
        load_use = 1'b1;
        tick(); settle();
        chk("rst_jump_en",     32'(jump_en_o),     32'h0);
        chk("rst_flush",       32'(flush_o),       32'h0);
        chk("rst_trap_ack",    32'(trap_ack_o),    32'h0);
        chk("rst_jump_addr",   jump_addr_o,        32'h0);
        chk("rst_stall_front", 32'(stall_front_o), 32'h0);
        chk("rst_bubble_ex",   32'(bubble_ex_o),   32'h0);
        rst = 1'b0;
        load_use = 1'b0;
        tick();

        // single jump
        ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0100;
        tick(); ex_jump_en = 1'b0; settle();
        chk("jmp_en",    32'(jump_en_o), 32'h1);
        chk("jmp_flush", 32'(flush_o),   32'h1);
        chk("jmp_addr",  jump_addr_o,    32'h100);
        tick(); settle();
        chk("jmp_en_after",    32'(jump_en_o), 32'h0);
        chk("jmp_flush_after", 32'(flush_o),   32'h0);
        chk("jmp_addr_hold",   jump_addr_o,    32'h100);

        // priority trap > mret > jump
        trap_req = 1'b1; trap_addr = 32'h800;
        mret_req = 1'b1; mret_addr = 32'h200;
        ex_jump_en = 1'b1; ex_jump_addr = 32'h100;
        tick(); trap_req = 1'b0; mret_req = 1'b0; ex_jump_en = 1'b0; settle();
        chk("prio_addr", jump_addr_o,     32'h800);
        chk("prio_ack",  32'(trap_ack_o), 32'h1);
        chk("prio_en",   32'(jump_en_o),  32'h1);
        tick(); settle();
        chk("prio_en_once",  32'(jump_en_o),  32'h0);
        chk("prio_ack_once", 32'(trap_ack_o), 32'h0);

        // back-to-back jumps: second lands in the REDIRECT cycle
        ex_jump_en = 1'b1; ex_jump_addr = 32'h300;
        tick(); ex_jump_addr = 32'h400; settle();
        chk("b2b_en",   32'(jump_en_o), 32'h1);
        chk("b2b_addr", jump_addr_o,    32'h300);
        tick(); ex_jump_en = 1'b0; settle();
        chk("b2b_no_second", 32'(jump_en_o), 32'h0);
        chk("b2b_addr_hold", jump_addr_o,    32'h300);

        // load-use alone, then with a jump
        load_use = 1'b1; settle();
        chk("lu_stall_front", 32'(stall_front_o), 32'h1);
        chk("lu_bubble",      32'(bubble_ex_o),   32'h1);
        chk("lu_stall_ex",    32'(stall_ex_o),    32'h0);
        tick(); ex_jump_en = 1'b1; ex_jump_addr = 32'h500; settle();
        chk("lujmp_stall_front", 32'(stall_front_o), 32'h0);
        chk("lujmp_bubble",      32'(bubble_ex_o),   32'h0);
        tick(); ex_jump_en = 1'b0; load_use = 1'b0; settle();
        chk("lujmp_en",   32'(jump_en_o), 32'h1);
        chk("lujmp_addr", jump_addr_o,    32'h500);
        tick();

        // divide with a trap arriving mid-wait
        div_start = 1'b1;
        tick(); div_start = 1'b0; settle();
        chk("div_c11_sf", 32'(stall_front_o), 32'h1);
        chk("div_c11_se", 32'(stall_ex_o),    32'h1);
        tick(); trap_req = 1'b1; trap_addr = 32'hA00; settle();
        chk("div_c12_sf", 32'(stall_front_o), 32'h1);
        tick(); settle();
        chk("div_c13_se", 32'(stall_ex_o), 32'h1);
        tick(); div_done = 1'b1; settle();
        chk("div_c14_sf", 32'(stall_front_o), 32'h0);
        chk("div_c14_se", 32'(stall_ex_o),    32'h0);
        chk("div_c14_en", 32'(jump_en_o),     32'h0);
        tick(); div_done = 1'b0; trap_req = 1'b0; settle();
        chk("div_c15_en",   32'(jump_en_o),  32'h1);
        chk("div_c15_ack",  32'(trap_ack_o), 32'h1);
        chk("div_c15_addr", jump_addr_o,     32'hA00);
        tick();

        // reset in the middle of a divide with a pending trap
        div_start = 1'b1;
        tick(); div_start = 1'b0; trap_req = 1'b1; trap_addr = 32'hB00;
        tick(); rst = 1'b1; trap_req = 1'b0; settle();
        chk("rstdiv_sf", 32'(stall_front_o), 32'h0);
        chk("rstdiv_se", 32'(stall_ex_o),    32'h0);
        tick(); rst = 1'b0; load_use = 1'b1; settle();
        chk("rstdiv_en",   32'(jump_en_o),     32'h0);
        chk("rstdiv_addr", jump_addr_o,        32'h0);
        chk("rstdiv_idle", 32'(stall_front_o), 32'h1);
        tick(); load_use = 1'b0; settle();
        chk("rstdiv_no_trap", 32'(jump_en_o), 32'h0);

        // randomized traffic; trap source holds its request until acknowledged
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            if (m_ack) begin
                trap_req = 1'b0;
            end else if (!trap_req && $urandom_range(0, 7) == 0) begin
                trap_req = 1'b1;
            end
            trap_addr    = $urandom;
            mret_req     = ($urandom_range(0, 7) == 0);
            mret_addr    = $urandom;
            ex_jump_en   = ($urandom_range(0, 3) == 0);
            ex_jump_addr = $urandom;
            div_start    = ($urandom_range(0, 5) == 0);
            div_done     = m_dividing && ($urandom_range(0, 3) == 0);
            load_use     = ($urandom_range(0, 3) == 0);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ex_jump_en_i  in  1  branch/jump resolved taken in EX.
REQ-004 ex_jump_addr_i  in  RV32_ADDR_WIDTH (32)  EX target.
REQ-005 trap_req_i  in  1  trap/interrupt entry request; level, held until trap_ack_o.
REQ-006 trap_addr_i  in  32  trap vector.
REQ-007 mret_req_i  in  1  mret in EX.
REQ-008 mret_addr_i  in  32  mepc.
REQ-009 div_start_i  in  1  multi-cycle divide issued from EX.
REQ-010 div_done_i  in  1  divider result valid (1-cycle pulse).
REQ-011 load_use_i  in  1  load-use hazard detected in ID.
REQ-012 jump_en_o  out  1  registered redirect to PC.
REQ-013 jump_addr_o  out  32  registered redirect target.
REQ-014 flush_o  out  1  registered flush of IF/ID and ID/EX.
REQ-015 stall_front_o  out  1  hold PC, IF/ID, ID/EX (combinational).
REQ-016 stall_ex_o  out  1  hold EX/MEM input (combinational).
REQ-017 bubble_ex_o  out  1  insert NOP into ID/EX (combinational).
REQ-018 trap_ack_o  out  1  registered one-cycle trap acceptance pulse.

Function
REQ-019 FSM states: IDLE, REDIRECT, DIV_WAIT; encoding 2 bits.
REQ-020 Redirect priority in a cycle: trap > mret > ex_jump; only winner's address used.
REQ-021 Redirect accepted in IDLE at cycle N: jump_en_o=1, flush_o=1, jump_addr_o=winner addr in cycle N+1, for exactly one cycle; state=REDIRECT in N+1.
REQ-022 trap win additionally: trap_ack_o=1 in cycle N+1.
REQ-023 REDIRECT lasts one cycle, then IDLE; in REDIRECT all of ex_jump_en_i, mret_req_i, div_start_i, load_use_i ignored (wrong-path); trap_req_i re-evaluated only after return to IDLE.
REQ-024 div_start_i in IDLE with no redirect request same cycle: state=DIV_WAIT next cycle; div_start_i with redirect same cycle: redirect wins, divide discarded.
REQ-025 DIV_WAIT: stall_front_o=1, stall_ex_o=1 while div_done_i=0; both drop combinationally in the div_done_i cycle; next state IDLE.
REQ-026 DIV_WAIT: ex_jump_en_i, mret_req_i, load_use_i ignored; trap_req_i sets trap_pend flag (address sampled from trap_addr_i at div_done_i cycle).
REQ-027 trap_pend set at div_done_i: redirect to trap treated as accepted in that cycle (outputs per REQ-021/022 next cycle); trap_pend cleared.
REQ-028 load_use_i in IDLE with no redirect/div_start: stall_front_o=1, bubble_ex_o=1 same cycle, stall_ex_o=0; no state change.
REQ-029 load_use_i and redirect same cycle: redirect wins; stall/bubble deasserted.
REQ-030 jump_addr_o holds last value when jump_en_o=0; no X propagation.
REQ-031 Back-to-back: request in cycle N+1 (REDIRECT) never produces second redirect in N+2.

Reset
REQ-032 rst=1 at any edge, any state: state=IDLE, trap_pend=0, jump_en_o=0, flush_o=0, trap_ack_o=0, jump_addr_o=0 next cycle.
REQ-033 Combinational stall_front_o, stall_ex_o, bubble_ex_o=0 while rst=1.
REQ-034 Reset mid-DIV_WAIT abandons divide; divider reset by same rst.

Structure
REQ-035 RV32_ADDR_WIDTH, JUMP_ENABLE/DISABLE, FLUSH_ENABLE/DISABLE, RST_DATA, state encodings in shared defines file.
REQ-036 Registered outputs built from existing resettable dff sub-module (dff_rs, rst_data port); FSM in this module.

Verification
REQ-037 ex_jump_en_i=1, addr 0x0000_0100 at cycle 5 -> cycle 6: jump_en_o=1, flush_o=1, jump_addr_o=0x100; cycle 7: all 0.
REQ-038 trap_req_i (0x0000_0800), mret (0x200), ex_jump (0x100) same cycle -> next cycle jump_addr_o=0x800, trap_ack_o=1; only one redirect.
REQ-039 div_start_i at cycle 10, div_done_i at 14 -> stall_front_o=stall_ex_o=1 cycles 11-13, 0 at 14; trap_req_i raised at 12 -> cycle 15 jump_en_o=1, trap_ack_o=1.
REQ-040 load_use_i=1 one cycle -> stall_front_o=1, bubble_ex_o=1 same cycle; with ex_jump_en_i same cycle -> no stall, redirect next cycle.
REQ-041 ex_jump at cycle 5 and again at cycle 6 -> single jump_en_o pulse at cycle 6 only.
REQ-042 rst=1 during DIV_WAIT -> next cycle state IDLE, all outputs 0, trap_pend cleared.
